// File: rtl/apb4_master_engine.sv
// APB4 requester: buffered commands in, one SETUP/ACCESS at a time,
// buffered responses out (read data, pslverr, timeout).
module apb4_master_engine #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int CMD_DEPTH      = 4,
  parameter int RSP_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    pclk,
  input  logic                    preset,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_write_i,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb_i,
  input  logic [2:0]              cmd_prot_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic                    rsp_tout_o,
  output logic                    busy_o,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic [2:0]              pprot,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pready,
  input  logic                    pslverr
);

  localparam int SW  = DATA_WIDTH / 8;
  localparam int CAW = $clog2(CMD_DEPTH);
  localparam int RAW = $clog2(RSP_DEPTH);
  localparam int CW  = ADDR_WIDTH + DATA_WIDTH + SW + 4;
  localparam int RW  = DATA_WIDTH + 2;
  localparam int TW  = (TIMEOUT_CYCLES > 1) ?
                       $clog2(TIMEOUT_CYCLES) : 1;
  localparam int TL  = (TIMEOUT_CYCLES > 0) ?
                       TIMEOUT_CYCLES - 1 : 0;

  localparam logic [TW-1:0]  TLIM  = TW'(TL);
  localparam logic [CAW:0]   CFULL = (CAW+1)'(CMD_DEPTH);
  localparam logic [RAW+1:0] RLIM  = (RAW+2)'(RSP_DEPTH);
  localparam logic           TEN   = (TIMEOUT_CYCLES != 0);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  logic [1:0]            state;
  logic [TW-1:0]         tcnt;

  logic [CW-1:0]         cmem [CMD_DEPTH];
  logic [CAW-1:0]        cwp, crp;
  logic [CAW:0]          ccnt;

  logic [RW-1:0]         rmem [RSP_DEPTH];
  logic [RAW-1:0]        rwp, rrp;
  logic [RAW:0]          rcnt;

  logic                  h_write;
  logic [2:0]            h_prot;
  logic [SW-1:0]         h_strb;
  logic [DATA_WIDTH-1:0] h_wdata;
  logic [ADDR_WIDTH-1:0] h_addr;

  logic                  cmd_push, rsp_push, rsp_pop;
  logic                  done, tmo, go, room;
  logic [RAW+1:0]        rnext;
  logic [RW-1:0]         rsp_din;
  logic [DATA_WIDTH-1:0] rd_keep;

  assign cmd_ready_o = (ccnt != CFULL);
  assign cmd_push    = cmd_valid_i && cmd_ready_o;

  assign {h_write, h_prot, h_strb, h_wdata, h_addr} = cmem[crp];

  assign done = (state == ACCESS) && pready;
  assign tmo  = (state == ACCESS) && !pready &&
                TEN && (tcnt == TLIM);

  // count the response landing this cycle so the next one has a slot
  assign rnext = {1'b0, rcnt} + {{(RAW+1){1'b0}}, done};
  assign room  = (rnext < RLIM);
  assign go    = ((state == IDLE) || done) &&
                 (ccnt != '0) && room;

  assign rsp_push = done || tmo;
  assign rsp_pop  = rsp_valid_o && rsp_ready_i;
  assign rd_keep  = pwrite ? '0 : prdata;
  assign rsp_din  = tmo ? {2'b11, {DATA_WIDTH{1'b0}}}
                        : {1'b0, pslverr, rd_keep};

  assign rsp_valid_o = (rcnt != '0);
  assign {rsp_tout_o, rsp_err_o, rsp_rdata_o} = rmem[rrp];

  assign busy_o = (state != IDLE) || (ccnt != '0);

  // command storage
  always_ff @(posedge pclk) begin
    if (cmd_push)
      cmem[cwp] <= {cmd_write_i, cmd_prot_i, cmd_strb_i,
                    cmd_wdata_i, cmd_addr_i};
  end

  // command pointers and occupancy
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      cwp  <= '0;
      crp  <= '0;
      ccnt <= '0;
    end else begin
      if (cmd_push) cwp <= cwp + CAW'(1);
      if (go)       crp <= crp + CAW'(1);
      unique case ({cmd_push, go})
        2'b10:   ccnt <= ccnt + (CAW+1)'(1);
        2'b01:   ccnt <= ccnt - (CAW+1)'(1);
        default: ;
      endcase
    end
  end

  // response storage
  always_ff @(posedge pclk) begin
    if (rsp_push) rmem[rwp] <= rsp_din;
  end

  // response pointers and occupancy
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      rwp  <= '0;
      rrp  <= '0;
      rcnt <= '0;
    end else begin
      if (rsp_push) rwp <= rwp + RAW'(1);
      if (rsp_pop)  rrp <= rrp + RAW'(1);
      unique case ({rsp_push, rsp_pop})
        2'b10:   rcnt <= rcnt + (RAW+1)'(1);
        2'b01:   rcnt <= rcnt - (RAW+1)'(1);
        default: ;
      endcase
    end
  end

  // transfer sequencer and registered APB outputs
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state   <= IDLE;
      tcnt    <= '0;
      psel    <= 1'b0;
      penable <= 1'b0;
      paddr   <= '0;
      pwdata  <= '0;
      pstrb   <= '0;
      pwrite  <= 1'b0;
      pprot   <= '0;
    end else begin
      unique case (1'b1)
        go: begin
          state   <= SETUP;
          psel    <= 1'b1;
          penable <= 1'b0;
          paddr   <= h_addr;
          pwdata  <= h_wdata;
          pwrite  <= h_write;
          pprot   <= h_prot;
          pstrb   <= h_write ? h_strb : '0;
        end
        (state == SETUP): begin
          state   <= ACCESS;
          penable <= 1'b1;
          tcnt    <= '0;
        end
        (done || tmo) && !go: begin
          state   <= IDLE;
          psel    <= 1'b0;
          penable <= 1'b0;
          paddr   <= '0;
          pwdata  <= '0;
          pstrb   <= '0;
          pwrite  <= 1'b0;
          pprot   <= '0;
        end
        (state == ACCESS) && !done && !tmo: begin
          tcnt <= tcnt + TW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb4_master_engine.sv
// Directed bench for apb4_master_engine with a small
// APB completer model and hand-computed expectations.
module tb_apb4_master_engine;

  logic        pclk = 1'b0;
  logic        preset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_strb = '0;
  logic [2:0]  cmd_prot = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err, rsp_tout, busy;
  logic [31:0] paddr, pwdata, prdata;
  logic [2:0]  pprot;
  logic        psel, penable, pwrite;
  logic [3:0]  pstrb;
  logic        pready = 1'b1;
  logic        pslverr = 1'b0;

  logic        use_model = 1'b0;
  logic [31:0] rd_value = '0;

  int vecs = 0;
  int errs = 0;
  int mon_psel = 0;
  int mon_done = 0;
  int mon_gap = 0;

  apb4_master_engine #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32),
    .CMD_DEPTH(4), .RSP_DEPTH(4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_write_i(cmd_write), .cmd_addr_i(cmd_addr),
    .cmd_wdata_i(cmd_wdata), .cmd_strb_i(cmd_strb),
    .cmd_prot_i(cmd_prot),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .rsp_tout_o(rsp_tout), .busy_o(busy),
    .paddr(paddr), .pprot(pprot), .psel(psel),
    .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata), .pready(pready),
    .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  assign prdata = use_model ? (paddr ^ 32'hA5A5_0000)
                            : rd_value;

  // free-running activity monitor, sampled mid-cycle
  always @(negedge pclk) begin
    if (psel) mon_psel <= mon_psel + 1;
    if (psel && penable && pready)
      mon_done <= mon_done + 1;
    if (busy && !psel) mon_gap <= mon_gap + 1;
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    vecs++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic push(input logic w,
                      input logic [31:0] a,
                      input logic [31:0] d,
                      input logic [3:0] s,
                      input logic [2:0] p);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_strb  = s;
    cmd_prot  = p;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    chk("push_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_psel(input string tag);
    int n = 0;
    while (!psel && n < 50) begin
      tick();
      n++;
    end
    chk(tag, psel, 1);
  endtask

  task automatic pop_rsp(input string tag,
                         input logic [31:0] rd,
                         input logic er,
                         input logic to);
    int n = 0;
    while (!rsp_valid && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, rsp_valid, 1);
    chk({tag, "_rdata"}, rsp_rdata, rd);
    chk({tag, "_err"}, rsp_err, er);
    chk({tag, "_tout"}, rsp_tout, to);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    int n;
    int b_psel, b_done, b_gap;
    int seen;
    logic [31:0] expq[$];

    #12;
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    @(negedge pclk);
    preset = 1'b0;
    tick();

    // single write, zero wait states
    push(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 3'h2);
    chk("wr_idle_psel", psel, 0);
    chk("wr_busy", busy, 1);
    tick();
    chk("wr_setup_psel", psel, 1);
    chk("wr_setup_pen", penable, 0);
    chk("wr_paddr", paddr, 32'h10);
    chk("wr_pwdata", pwdata, 32'hDEAD_BEEF);
    chk("wr_pstrb", pstrb, 4'hF);
    chk("wr_pwrite", pwrite, 1);
    chk("wr_pprot", pprot, 3'h2);
    tick();
    chk("wr_acc_pen", penable, 1);
    chk("wr_acc_paddr", paddr, 32'h10);
    chk("wr_acc_rsp", rsp_valid, 0);
    tick();
    chk("wr_done_psel", psel, 0);
    chk("wr_done_paddr", paddr, 0);
    chk("wr_done_pwdata", pwdata, 0);
    pop_rsp("wr", 32'h0, 1'b0, 1'b0);

    // write answered with pslverr
    pslverr = 1'b1;
    push(1'b1, 32'h14, 32'h55, 4'h3, 3'h0);
    wait_psel("err_psel");
    tick();
    tick();
    pslverr = 1'b0;
    pop_rsp("slverr", 32'h0, 1'b1, 1'b0);

    // read with 3 wait states
    rd_value = 32'h1234_5678;
    pready = 1'b0;
    push(1'b0, 32'h20, 32'h0, 4'hF, 3'h0);
    tick();
    chk("rd_paddr", paddr, 32'h20);
    chk("rd_pwrite", pwrite, 0);
    chk("rd_setup_pstrb", pstrb, 0);
    tick();
    n = 0;
    while (psel && penable && n < 20) begin
      n++;
      chk("rd_acc_pstrb", pstrb, 0);
      if (n == 4) pready = 1'b1;
      tick();
    end
    pready = 1'b0;
    chk("rd_acc_cycles", n, 4);
    chk("rd_done_psel", psel, 0);
    pop_rsp("rd", 32'h1234_5678, 1'b0, 1'b0);

    // back-to-back reads until the response FIFO fills
    pready = 1'b1;
    use_model = 1'b1;
    b_psel = mon_psel;
    b_done = mon_done;
    b_gap = mon_gap;
    for (int i = 1; i <= 4; i++)
      push(1'b0, 32'h100 + 32'(4 * i), 32'h0, 4'h0, 3'h0);
    n = 0;
    while ((mon_done - b_done) < 4 && n < 50) begin
      tick();
      n++;
    end
    chk("b2b_done", mon_done - b_done, 4);
    chk("b2b_psel_cycles", mon_psel - b_psel, 8);
    chk("b2b_idle_gap", mon_gap - b_gap, 1);
    chk("b2b_end_psel", psel, 0);
    tick();
    chk("b2b_rsp_valid", rsp_valid, 1);

    // stalled FSM: fill the command FIFO
    for (int i = 5; i <= 8; i++) begin
      push(1'b0, 32'h100 + 32'(4 * i), 32'h0, 4'h0, 3'h0);
      chk("full_ready", cmd_ready, (i < 8) ? 1 : 0);
    end
    cmd_valid = 1'b1;
    cmd_addr = 32'h1F0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_psel", psel, 0);
      chk("stall_ready", cmd_ready, 0);
    end
    chk("pop1_rdata", rsp_rdata, 32'h104 ^ 32'hA5A5_0000);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("popA_ready", cmd_ready, 0);
    chk("popA_psel", psel, 0);
    tick();
    chk("popB_psel", psel, 1);
    chk("popB_ready", cmd_ready, 1);
    cmd_valid = 1'b0;

    for (int i = 2; i <= 8; i++)
      expq.push_back(32'h100 + 32'(4 * i));
    rsp_ready = 1'b1;
    n = 0;
    while (expq.size() > 0 && n < 100) begin
      if (rsp_valid) begin
        chk("drain_rdata", rsp_rdata,
            expq[0] ^ 32'hA5A5_0000);
        void'(expq.pop_front());
      end
      tick();
      n++;
    end
    rsp_ready = 1'b0;
    chk("drain_left", expq.size(), 0);
    tick();
    chk("drain_busy", busy, 0);
    chk("drain_rsp", rsp_valid, 0);
    use_model = 1'b0;

    // timeout with pready stuck low
    rd_value = 32'hFFFF_FFFF;
    pready = 1'b0;
    push(1'b0, 32'h40, 32'h0, 4'hF, 3'h1);
    wait_psel("to_psel");
    tick();
    n = 0;
    while (penable && n < 30) begin
      n++;
      tick();
    end
    chk("to_acc_cycles", n, 8);
    chk("to_psel_drop", psel, 0);
    pop_rsp("tout", 32'h0, 1'b1, 1'b1);

    // completion on the last allowed ACCESS cycle
    rd_value = 32'h0BAD_CAFE;
    push(1'b0, 32'h48, 32'h0, 4'h0, 3'h0);
    wait_psel("edge_psel");
    tick();
    n = 0;
    while (penable && n < 30) begin
      n++;
      if (n == 8) pready = 1'b1;
      tick();
    end
    pready = 1'b0;
    chk("edge_acc_cycles", n, 8);
    pop_rsp("edge", 32'h0BAD_CAFE, 1'b0, 1'b0);

    // normal write after a timeout
    pready = 1'b1;
    push(1'b1, 32'h44, 32'hCAFE_F00D, 4'h5, 3'h0);
    wait_psel("post_psel");
    chk("post_paddr", paddr, 32'h44);
    chk("post_pstrb", pstrb, 4'h5);
    pop_rsp("post", 32'h0, 1'b0, 1'b0);

    // reset in the middle of ACCESS
    pready = 1'b0;
    push(1'b0, 32'h60, 32'h0, 4'h0, 3'h0);
    push(1'b0, 32'h64, 32'h0, 4'h0, 3'h0);
    n = 0;
    while (!penable && n < 50) begin
      tick();
      n++;
    end
    chk("mid_penable", penable, 1);
    #2;
    preset = 1'b1;
    #1;
    chk("mrst_psel", psel, 0);
    chk("mrst_penable", penable, 0);
    chk("mrst_paddr", paddr, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_ready", cmd_ready, 1);
    chk("mrst_rsp", rsp_valid, 0);
    @(negedge pclk);
    preset = 1'b0;
    pready = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rsp_valid || psel) seen++;
    end
    chk("mrst_quiet", seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
